// File: rtl/regfile_pkg.sv
// Shared register-bank definitions for the RV32I pipeline stages.
package regfile_pkg;

    localparam int NUM_REGS = 32;
    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 32;

    localparam logic [ADDR_W-1:0] ZERO_REG = 5'd0;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/regfile_wb_scheduler_if.sv
// Issue, writeback-request and bank write-port signals of the writeback scheduler.
interface regfile_wb_scheduler_if #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 32
) ();

    logic                              iss_valid;
    logic [ADDR_W-1:0]                 iss_rs1;
    logic [ADDR_W-1:0]                 iss_rs2;
    logic [ADDR_W-1:0]                 iss_rd;
    logic                              iss_rd_en;
    logic                              iss_stall;

    logic [NUM_REQ-1:0]                req_valid;
    logic [NUM_REQ*ADDR_W-1:0]         req_addr;
    logic [NUM_REQ*DATA_W-1:0]         req_data;
    logic [NUM_REQ-1:0]                req_ready;

    logic                              wb_en;
    logic [ADDR_W-1:0]                 wb_addr;
    logic [DATA_W-1:0]                 wb_data;
    logic [regfile_pkg::NUM_REGS-1:0]  pending;

    modport master (
        output iss_valid, iss_rs1, iss_rs2, iss_rd, iss_rd_en,
        output req_valid, req_addr, req_data,
        input  iss_stall, req_ready, wb_en, wb_addr, wb_data, pending
    );

    modport slave (
        input  iss_valid, iss_rs1, iss_rs2, iss_rd, iss_rd_en,
        input  req_valid, req_addr, req_data,
        output iss_stall, req_ready, wb_en, wb_addr, wb_data, pending
    );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant, scan starts one past the last accepted index.
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         accept,
    output logic [N-1:0] grant
);

    localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

    logic [PTR_W-1:0] last;
    logic [PTR_W-1:0] winner;
    logic [PTR_W-1:0] idx;
    logic             found;

    always_comb begin
        grant  = '0;
        winner = last;
        idx    = '0;
        found  = 1'b0;
        for (int k = 1; k <= N; k++) begin
            idx = PTR_W'((int'(last) + k) % N);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                winner     = idx;
                found      = 1'b1;
            end
        end
    end

    // Pointer only moves on an accepted grant so an idle cycle keeps the rotation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last <= PTR_W'(N - 1);
        end else if (accept) begin
            last <= winner;
        end
    end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Writeback port scheduler and pending-register scoreboard for the 32x32 register bank.
module regfile_wb_scheduler #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 32
) (
    input logic                    clk,
    input logic                    rst,
    regfile_wb_scheduler_if.slave  bus
);

    import regfile_pkg::*;

    logic [NUM_REQ-1:0]  grant;
    logic                hs;
    wb_req_t             sel;
    wb_req_t             wb_q;
    logic [NUM_REGS-1:0] pending_q;
    logic [NUM_REGS-1:0] pending_nxt;
    logic                stall;
    logic                fire;

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .clk    (clk),
        .rst    (rst),
        .req    (bus.req_valid),
        .accept (hs),
        .grant  (grant)
    );

    always_comb begin
        sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel.valid = 1'b1;
                sel.addr  = bus.req_addr[i*ADDR_W +: ADDR_W];
                sel.data  = bus.req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign hs = sel.valid;

    // Address-0 requests are consumed here but never reach the bank.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_q <= '0;
        end else begin
            wb_q.valid <= hs && (sel.addr != ZERO_REG);
            if (hs) begin
                wb_q.addr <= sel.addr;
                wb_q.data <= sel.data;
            end
        end
    end

    // Bit 0 is never set, so indexing with x0 reads 0 without special casing.
    assign stall = bus.iss_valid &
                   (pending_q[bus.iss_rs1] | pending_q[bus.iss_rs2] |
                    (bus.iss_rd_en & pending_q[bus.iss_rd]));
    assign fire  = bus.iss_valid & ~stall;

    // Set is applied after clear so a same-cycle set of the landing register wins.
    always_comb begin
        pending_nxt = pending_q;
        if (wb_q.valid) begin
            pending_nxt[wb_q.addr] = 1'b0;
        end
        if (fire && bus.iss_rd_en && (bus.iss_rd != ZERO_REG)) begin
            pending_nxt[bus.iss_rd] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_nxt;
        end
    end

    assign bus.iss_stall = stall;
    assign bus.req_ready = grant;
    assign bus.wb_en     = wb_q.valid;
    assign bus.wb_addr   = wb_q.addr;
    assign bus.wb_data   = wb_q.data;
    assign bus.pending   = pending_q;

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Directed and random checks of the writeback scheduler against a reference scoreboard model.
module tb_regfile_wb_scheduler;

    localparam int NUM_REQ = 2;
    localparam int ADDR_W  = 5;
    localparam int DATA_W  = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    regfile_wb_scheduler_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    regfile_wb_scheduler #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Bank model written from the DUT write port; initial contents tag each register.
    logic [DATA_W-1:0] bank [32];
    bit bank_init = 1'b0;
    always @(posedge clk) begin
        if (!bank_init) begin
            for (int i = 0; i < 32; i++) bank[i] = 32'hA000_0000 | i;
            bank_init = 1'b1;
        end
        if (bus.wb_en) bank[bus.wb_addr] = bus.wb_data;
    end

    // Reference model: own round-robin pointer, pending bitmap and expected write-port queue.
    typedef struct {
        logic              en;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_exp_t;

    wb_exp_t     exp_q [$];
    logic [31:0] m_pending;
    int          m_last;
    int          wait_cnt [NUM_REQ];

    always @(negedge clk) begin
        logic [NUM_REQ-1:0] m_grant;
        int                 gi;
        int                 j;
        logic               m_stall;
        logic [31:0]        p_nxt;
        wb_exp_t            cur;
        wb_exp_t            nxt;
        if (rst) begin
            m_pending = '0;
            m_last    = NUM_REQ - 1;
            for (int i = 0; i < NUM_REQ; i++) wait_cnt[i] = 0;
            exp_q.delete();
            cur.en = 1'b0; cur.addr = '0; cur.data = '0;
            exp_q.push_back(cur);
        end else begin
            m_grant = '0;
            gi      = -1;
            for (int k = 1; k <= NUM_REQ; k++) begin
                j = (m_last + k) % NUM_REQ;
                if (gi < 0 && bus.req_valid[j]) begin
                    gi         = j;
                    m_grant[j] = 1'b1;
                end
            end
            m_stall = bus.iss_valid && (m_pending[bus.iss_rs1] || m_pending[bus.iss_rs2] ||
                                        (bus.iss_rd_en && m_pending[bus.iss_rd]));
            check("sb_ready", bus.req_ready, m_grant);
            check("sb_onehot", $countones(bus.req_ready) <= 1, 1);
            check("sb_stall", bus.iss_stall, m_stall);
            check("sb_pending", bus.pending, m_pending);
            check("sb_queue_size", exp_q.size(), 1);
            cur.en = 1'b0; cur.addr = '0; cur.data = '0;
            if (exp_q.size() > 0) cur = exp_q.pop_front();
            check("sb_wb_en", bus.wb_en, cur.en);
            check("sb_wb_addr", bus.wb_addr, cur.addr);
            check("sb_wb_data", bus.wb_data, cur.data);
            for (int i = 0; i < NUM_REQ; i++) begin
                if (bus.req_valid[i] && !bus.req_ready[i]) wait_cnt[i]++;
                else wait_cnt[i] = 0;
                if (bus.req_valid[i]) check("sb_starve", wait_cnt[i] <= NUM_REQ - 1, 1);
            end
            nxt    = cur;
            nxt.en = 1'b0;
            if (gi >= 0) begin
                nxt.addr = bus.req_addr[gi*ADDR_W +: ADDR_W];
                nxt.data = bus.req_data[gi*DATA_W +: DATA_W];
                nxt.en   = (nxt.addr != 0);
            end
            exp_q.push_back(nxt);
            p_nxt = m_pending;
            if (cur.en) p_nxt[cur.addr] = 1'b0;
            if (bus.iss_valid && !m_stall && bus.iss_rd_en && bus.iss_rd != 0) p_nxt[bus.iss_rd] = 1'b1;
            m_pending = p_nxt;
            if (gi >= 0) m_last = gi;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.iss_valid = 1'b0;
        bus.iss_rs1   = '0;
        bus.iss_rs2   = '0;
        bus.iss_rd    = '0;
        bus.iss_rd_en = 1'b0;
        bus.req_valid = '0;
        bus.req_addr  = '0;
        bus.req_data  = '0;
    endtask

    task automatic issue(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic rd_en);
        bus.iss_valid = 1'b1;
        bus.iss_rs1   = rs1;
        bus.iss_rs2   = rs2;
        bus.iss_rd    = rd;
        bus.iss_rd_en = rd_en;
    endtask

    task automatic req(input int i, input logic [4:0] a, input logic [31:0] d);
        bus.req_valid[i]                   = 1'b1;
        bus.req_addr[i*ADDR_W +: ADDR_W]   = a;
        bus.req_data[i*DATA_W +: DATA_W]   = d;
    endtask

    function automatic logic [4:0] pick_addr();
        int start;
        if (m_pending != 0 && $urandom_range(0, 3) != 0) begin
            start = $urandom_range(0, 31);
            for (int k = 0; k < 32; k++) begin
                if (m_pending[(start + k) % 32]) return 5'((start + k) % 32);
            end
        end
        return 5'($urandom_range(0, 31));
    endfunction

    initial begin
        idle();
        rst = 1'b1;
        repeat (2) tick();
        check("rst_wb_en", bus.wb_en, 0);
        check("rst_wb_addr", bus.wb_addr, 0);
        check("rst_wb_data", bus.wb_data, 0);
        check("rst_pending", bus.pending, 0);
        rst = 1'b0;

        // Both requesters held valid: alternating grants starting with 0.
        req(0, 5'd3, 32'h0000_0033);
        req(1, 5'd4, 32'h0000_0044);
        for (int k = 0; k < 4; k++) begin
            #1;
            check("rr_grant", bus.req_ready, (k % 2 == 0) ? 2'b01 : 2'b10);
            tick();
            check("rr_wb_en", bus.wb_en, 1);
            check("rr_wb_addr", bus.wb_addr, (k % 2 == 0) ? 3 : 4);
        end
        idle();
        tick();

        // RAW: rd=5 in flight, dependent instruction stalls until the write lands.
        issue(5'd0, 5'd0, 5'd5, 1'b1);
        #1;
        check("raw_producer_stall", bus.iss_stall, 0);
        tick();
        idle();
        check("raw_pending5", bus.pending, 32'h0000_0020);
        issue(5'd5, 5'd0, 5'd6, 1'b1);
        #1;
        check("raw_stall", bus.iss_stall, 1);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("raw_stall_hold", bus.iss_stall, 1);
        end
        req(0, 5'd5, 32'hDEAD_BEEF);
        #1;
        check("raw_grant_n", bus.req_ready, 2'b01);
        check("raw_stall_n", bus.iss_stall, 1);
        tick();
        bus.req_valid = '0;
        check("raw_wb_en_n1", bus.wb_en, 1);
        check("raw_wb_addr_n1", bus.wb_addr, 5);
        check("raw_wb_data_n1", bus.wb_data, 32'hDEAD_BEEF);
        #1;
        check("raw_stall_n1", bus.iss_stall, 1);
        tick();
        check("raw_stall_n2", bus.iss_stall, 0);
        check("raw_bank5", bank[5], 32'hDEAD_BEEF);
        tick();
        idle();
        check("raw_pending6", bus.pending, 32'h0000_0040);
        req(1, 5'd6, 32'h0000_0066);
        tick();
        idle();
        tick();
        check("raw_drained", bus.pending, 0);

        // WAW on rd=9, then rd=0 never stalls and never sets bit 0.
        issue(5'd0, 5'd0, 5'd9, 1'b1);
        tick();
        issue(5'd0, 5'd0, 5'd9, 1'b1);
        #1;
        check("waw_stall", bus.iss_stall, 1);
        tick();
        check("waw_pending", bus.pending, 32'h0000_0200);
        issue(5'd0, 5'd0, 5'd0, 1'b1);
        #1;
        check("rd0_stall", bus.iss_stall, 0);
        tick();
        idle();
        check("rd0_pending", bus.pending, 32'h0000_0200);
        req(1, 5'd9, 32'h0000_0099);
        tick();
        idle();
        tick();
        check("waw_drained", bus.pending, 0);

        // Address-0 request is consumed without a write.
        issue(5'd0, 5'd0, 5'd11, 1'b1);
        tick();
        idle();
        req(0, 5'd0, 32'h0000_1234);
        #1;
        check("a0_ready", bus.req_ready, 2'b01);
        tick();
        idle();
        check("a0_wb_en", bus.wb_en, 0);
        check("a0_pending", bus.pending, 32'h0000_0800);
        tick();
        check("a0_bank0", bank[0], 32'hA000_0000);
        req(0, 5'd11, 32'h0000_00BB);
        tick();
        idle();
        tick();
        check("a0_drained", bus.pending, 0);

        // Reset while a write to r7 sits on the port.
        issue(5'd0, 5'd0, 5'd12, 1'b1);
        tick();
        idle();
        req(0, 5'd7, 32'h0000_7777);
        tick();
        idle();
        check("rstw_wb_en_pre", bus.wb_en, 1);
        check("rstw_wb_addr_pre", bus.wb_addr, 7);
        check("rstw_pending_pre", bus.pending, 32'h0000_1000);
        rst = 1'b1;
        #1;
        check("rstw_wb_en_async", bus.wb_en, 0);
        tick();
        rst = 1'b0;
        check("rstw_wb_en", bus.wb_en, 0);
        check("rstw_pending", bus.pending, 0);
        check("rstw_bank7", bank[7], 32'hA000_0007);

        // Random issue/complete stream; the negedge model checks every cycle.
        for (int c = 0; c < 10000; c++) begin
            bus.iss_valid = ($urandom_range(0, 3) != 0);
            bus.iss_rs1   = 5'($urandom_range(0, 31));
            bus.iss_rs2   = 5'($urandom_range(0, 31));
            bus.iss_rd    = 5'($urandom_range(0, 31));
            bus.iss_rd_en = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < NUM_REQ; i++) begin
                bus.req_valid[i]                 = ($urandom_range(0, 3) != 0);
                bus.req_addr[i*ADDR_W +: ADDR_W] = pick_addr();
                bus.req_data[i*DATA_W +: DATA_W] = $urandom;
            end
            tick();
        end
        idle();
        repeat (4) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
